hpm_window_sequencer: RTL and testbench

//  Drives the HPM tracer/detector path. It writes mcountinhibit (CSR 0x320) to open
//  and close counting windows. At window close it freezes a snapshot of the HPM

---
 rtl/hpm_pkg.sv | 20 ++
 rtl/hpm_down_counter.sv | 37 +++
 rtl/hpm_window_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_hpm_window_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_pkg.sv
// rtl/hpm_pkg.sv - shared states, CSR constants and word type for the HPM window sequencer
package hpm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_COUNT,
    S_STOP,
    S_SNAP,
    S_DETECT,
    S_GAP
  } hpm_seq_state_t;

  typedef logic [31:0] hpm_word_t;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam hpm_word_t   HPM_CNT_ENABLE    = 32'h0000_0000;
  localparam hpm_word_t   HPM_CNT_INHIBIT   = 32'hFFFF_FFFF;

endpackage

// File: rtl/hpm_down_counter.sv
// rtl/hpm_down_counter.sv - loadable down counter that holds at zero
module hpm_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_h,
  input  logic         rst_h,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hpm_window_sequencer.sv
// rtl/hpm_window_sequencer.sv - opens/closes HPM counting windows via mcountinhibit
// and hands a frozen counter snapshot to the detector with a valid/done handshake.
module hpm_window_sequencer
  import hpm_pkg::*;
#(
  parameter int NUM_CNT     = 3,
  parameter int WIN_W       = 16,
  parameter int DET_TIMEOUT = 1024
) (
  input  logic                    clk_h,
  input  logic                    rst_h,
  input  logic                    cfg_en,
  input  logic [WIN_W-1:0]        cfg_window,
  input  logic [WIN_W-1:0]        cfg_gap,
  input  logic [1:0]              cfg_target,
  input  logic [NUM_CNT*32-1:0]   hpm_in,
  output logic                    csr_we_o,
  output logic [11:0]             csr_add_o,
  output logic [31:0]             csr_data_o,
  output logic [NUM_CNT*32-1:0]   hpm_o,
  output logic                    det_valid_o,
  input  logic                    det_done_i,
  output logic [1:0]              target_o,
  output logic                    busy_o,
  output logic                    timeout_o,
  output logic [15:0]             win_cnt_o
);

  localparam logic [WIN_W-1:0] TMO_LOAD = WIN_W'(DET_TIMEOUT);

  hpm_seq_state_t state_q, state_d;
  logic                  abort_q, abort_d;
  logic                  en_prev_q, en_prev_d;
  logic [1:0]            target_q, target_d;
  logic                  csr_we_q, csr_we_d;
  logic [11:0]           csr_add_q, csr_add_d;
  hpm_word_t             csr_data_q, csr_data_d;
  logic [NUM_CNT*32-1:0] hpm_q, hpm_d;
  logic                  det_valid_q, det_valid_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           win_cnt_q, win_cnt_d;

  logic [WIN_W-1:0] win_load_val;
  logic [WIN_W-1:0] win_cnt, gap_cnt, tmo_cnt;
  logic             win_zero, gap_zero, tmo_zero;
  logic             win_last, gap_last, tmo_last;

  assign win_load_val = (cfg_window == '0) ? WIN_W'(1) : cfg_window;

  hpm_down_counter #(.W(WIN_W)) u_win_ctr (
    .clk_h    (clk_h),
    .rst_h    (rst_h),
    .load     (state_q == S_START),
    .load_val (win_load_val),
    .dec      (state_q == S_COUNT),
    .cnt      (win_cnt),
    .zero     (win_zero)
  );

  // Reloaded every DETECT cycle so the value in force at GAP entry is used.
  hpm_down_counter #(.W(WIN_W)) u_gap_ctr (
    .clk_h    (clk_h),
    .rst_h    (rst_h),
    .load     (state_q == S_DETECT),
    .load_val (cfg_gap),
    .dec      (state_q == S_GAP),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  hpm_down_counter #(.W(WIN_W)) u_tmo_ctr (
    .clk_h    (clk_h),
    .rst_h    (rst_h),
    .load     (state_q == S_SNAP),
    .load_val (TMO_LOAD),
    .dec      (state_q == S_DETECT),
    .cnt      (tmo_cnt),
    .zero     (tmo_zero)
  );

  assign win_last = win_zero || (win_cnt == WIN_W'(1));
  assign gap_last = gap_zero || (gap_cnt == WIN_W'(1));
  assign tmo_last = tmo_zero || (tmo_cnt == WIN_W'(1));

  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    en_prev_d   = cfg_en;
    target_d    = target_q;
    hpm_d       = hpm_q;
    timeout_d   = timeout_q;
    win_cnt_d   = win_cnt_q;
    csr_we_d    = 1'b0;
    csr_add_d   = 12'h000;
    csr_data_d  = HPM_CNT_ENABLE;

    if (cfg_en && !en_prev_q) begin
      timeout_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cfg_en) begin
          state_d  = S_START;
          target_d = cfg_target;
          abort_d  = 1'b0;
        end
      end
      S_START: state_d = S_COUNT;
      S_COUNT: begin
        if (!cfg_en) begin
          state_d = S_STOP;
          abort_d = 1'b1;
        end else if (win_last) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        state_d = abort_q ? S_IDLE : S_SNAP;
        abort_d = 1'b0;
      end
      S_SNAP: begin
        hpm_d   = hpm_in;
        state_d = S_DETECT;
      end
      S_DETECT: begin
        if (det_done_i) begin
          state_d = S_GAP;
          hpm_d   = '0;
          if (win_cnt_q != 16'hFFFF) begin
            win_cnt_d = win_cnt_q + 16'd1;
          end
        end else if (tmo_last) begin
          state_d   = S_GAP;
          hpm_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          if (cfg_en) begin
            state_d  = S_START;
            target_d = cfg_target;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (state_d == S_START) begin
      csr_we_d   = 1'b1;
      csr_add_d  = CSR_MCOUNTINHIBIT;
      csr_data_d = HPM_CNT_ENABLE;
    end else if (state_d == S_STOP) begin
      csr_we_d   = 1'b1;
      csr_add_d  = CSR_MCOUNTINHIBIT;
      csr_data_d = HPM_CNT_INHIBIT;
    end
    det_valid_d = (state_d == S_DETECT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q     <= S_IDLE;
      abort_q     <= 1'b0;
      en_prev_q   <= 1'b0;
      target_q    <= 2'b00;
      csr_we_q    <= 1'b0;
      csr_add_q   <= 12'h000;
      csr_data_q  <= '0;
      hpm_q       <= '0;
      det_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      win_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      en_prev_q   <= en_prev_d;
      target_q    <= target_d;
      csr_we_q    <= csr_we_d;
      csr_add_q   <= csr_add_d;
      csr_data_q  <= csr_data_d;
      hpm_q       <= hpm_d;
      det_valid_q <= det_valid_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign csr_we_o    = csr_we_q;
  assign csr_add_o   = csr_add_q;
  assign csr_data_o  = csr_data_q;
  assign hpm_o       = hpm_q;
  assign det_valid_o = det_valid_q;
  assign target_o    = target_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;
  assign win_cnt_o   = win_cnt_q;

endmodule

// File: tb/tb_hpm_window_sequencer.sv
// tb/tb_hpm_window_sequencer.sv - directed self-checking bench for hpm_window_sequencer
module tb_hpm_window_sequencer;

  logic        clk_h = 1'b0;
  logic        rst_h;
  logic        cfg_en;
  logic [15:0] cfg_window;
  logic [15:0] cfg_gap;
  logic [1:0]  cfg_target;
  logic [95:0] hpm_in;
  logic        csr_we_o;
  logic [11:0] csr_add_o;
  logic [31:0] csr_data_o;
  logic [95:0] hpm_o;
  logic        det_valid_o;
  logic        det_done_i;
  logic [1:0]  target_o;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] win_cnt_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 32'd0;
  logic [95:0] snap;

  hpm_window_sequencer #(
    .NUM_CNT     (3),
    .WIN_W       (16),
    .DET_TIMEOUT (8)
  ) dut (
    .clk_h       (clk_h),
    .rst_h       (rst_h),
    .cfg_en      (cfg_en),
    .cfg_window  (cfg_window),
    .cfg_gap     (cfg_gap),
    .cfg_target  (cfg_target),
    .hpm_in      (hpm_in),
    .csr_we_o    (csr_we_o),
    .csr_add_o   (csr_add_o),
    .csr_data_o  (csr_data_o),
    .hpm_o       (hpm_o),
    .det_valid_o (det_valid_o),
    .det_done_i  (det_done_i),
    .target_o    (target_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .win_cnt_o   (win_cnt_o)
  );

  always #5 clk_h = ~clk_h;

  // Advance one clock, then present a fresh, distinct counter pattern.
  task automatic tick();
    @(posedge clk_h);
    #1;
    cyc    = cyc + 32'd1;
    hpm_in = {32'hC000_0000 + cyc, 32'hB000_0000 + cyc, 32'hA000_0000 + cyc};
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic we, input logic [31:0] data);
    chk({tag, "_we"}, csr_we_o, we);
    chk({tag, "_add"}, csr_add_o, we ? 12'h320 : 12'h000);
    chk({tag, "_data"}, csr_data_o, data);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, csr_we_o, 0);
    chk({tag, "_add"}, csr_add_o, 0);
    chk({tag, "_data"}, csr_data_o, 0);
    chk({tag, "_hpm"}, hpm_o, 0);
    chk({tag, "_valid"}, det_valid_o, 0);
    chk({tag, "_target"}, target_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_wincnt"}, win_cnt_o, 0);
  endtask

  initial begin
    rst_h = 1'b0; cfg_en = 1'b0; cfg_window = 16'd0; cfg_gap = 16'd0;
    cfg_target = 2'd0; det_done_i = 1'b0; hpm_in = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst_h = 1'b1;
    tick(); tick();
    chk("idle_busy", busy_o, 0);
    chk_csr("idle_csr", 0, 32'h0);

    // T1: window 4, gap 2, done three cycles after valid
    cfg_window = 16'd4; cfg_gap = 16'd2; cfg_target = 2'd2; cfg_en = 1'b1;
    tick();
    chk_csr("t1_start", 1, 32'h0);
    chk("t1_target", target_o, 2);
    chk("t1_busy", busy_o, 1);
    cfg_target = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_csr("t1_count", 0, 32'h0);
      chk("t1_count_valid", det_valid_o, 0);
    end
    tick();
    chk_csr("t1_stop", 1, 32'hFFFF_FFFF);
    tick();
    chk("t1_snap_valid", det_valid_o, 0);
    chk_csr("t1_snap_csr", 0, 32'h0);
    snap = hpm_in;
    tick();
    chk("t1_det_valid", det_valid_o, 1);
    chk("t1_det_hpm", hpm_o, snap);
    chk("t1_det_target", target_o, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_det_hold_valid", det_valid_o, 1);
      chk("t1_det_hold_hpm", hpm_o, snap);
    end
    det_done_i = 1'b1;
    tick();
    det_done_i = 1'b0;
    chk("t1_gap_valid", det_valid_o, 0);
    chk("t1_gap_wincnt", win_cnt_o, 1);
    chk("t1_gap_hpm", hpm_o, 0);
    chk("t1_gap_busy", busy_o, 1);
    cfg_window = 16'd0;
    tick();
    chk_csr("t1_gap2", 0, 32'h0);
    tick();
    chk_csr("t2_start", 1, 32'h0);
    chk("t2_target", target_o, 1);

    // T2: zero window lasts exactly one COUNT cycle
    tick();
    chk_csr("t2_count", 0, 32'h0);
    tick();
    chk_csr("t2_stop", 1, 32'hFFFF_FFFF);

    // T3: done tied high, gap 0, window 3
    det_done_i = 1'b1; cfg_gap = 16'd0; cfg_window = 16'd3;
    tick();
    chk("t3_snap_valid", det_valid_o, 0);
    tick();
    chk("t3_det_valid", det_valid_o, 1);
    tick();
    chk("t3_gap_valid", det_valid_o, 0);
    chk("t3_gap_wincnt", win_cnt_o, 2);
    for (int w = 0; w < 2; w++) begin
      tick();
      chk_csr("t3_start", 1, 32'h0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk_csr("t3_count", 0, 32'h0);
        chk("t3_count_valid", det_valid_o, 0);
        chk("t3_count_busy", busy_o, 1);
      end
      tick();
      chk_csr("t3_stop", 1, 32'hFFFF_FFFF);
      tick();
      chk("t3_snap_valid2", det_valid_o, 0);
      tick();
      chk("t3_det_valid2", det_valid_o, 1);
      tick();
      chk("t3_gap_valid2", det_valid_o, 0);
      chk("t3_gap_wincnt2", win_cnt_o, 16'(3 + w));
    end

    // T4: done tied low, timeout after 8 DETECT cycles
    det_done_i = 1'b0;
    tick();
    chk_csr("t4_start", 1, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk_csr("t4_last_count", 0, 32'h0);
    tick();
    chk_csr("t4_stop", 1, 32'hFFFF_FFFF);
    tick();
    chk("t4_snap_valid", det_valid_o, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_det_valid", det_valid_o, 1);
      chk("t4_det_timeout", timeout_o, 0);
    end
    tick();
    chk("t4_gap_valid", det_valid_o, 0);
    chk("t4_gap_timeout", timeout_o, 1);
    chk("t4_gap_wincnt", win_cnt_o, 4);
    cfg_en = 1'b0;
    tick();
    chk("t4_idle_busy", busy_o, 0);
    chk("t4_idle_timeout", timeout_o, 1);
    tick();
    chk("t4_idle_timeout2", timeout_o, 1);
    cfg_en = 1'b1;
    tick();
    chk_csr("t4_restart", 1, 32'h0);
    chk("t4_cleared", timeout_o, 0);

    // T5: cfg_en dropped mid-COUNT aborts with an inhibit write
    tick();
    chk("t5_count_busy", busy_o, 1);
    cfg_en = 1'b0;
    tick();
    chk_csr("t5_stop", 1, 32'hFFFF_FFFF);
    tick();
    chk("t5_idle_busy", busy_o, 0);
    chk_csr("t5_idle_csr", 0, 32'h0);
    chk("t5_idle_valid", det_valid_o, 0);
    tick();
    chk("t5_idle_valid2", det_valid_o, 0);
    chk("t5_wincnt", win_cnt_o, 4);

    // T6a: async reset while in DETECT
    cfg_window = 16'd0; cfg_en = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_det_valid", det_valid_o, 1);
    #2;
    rst_h = 1'b0;
    #1;
    chk_all_zero("t6_rst_det");
    cfg_en = 1'b0;
    tick();
    rst_h = 1'b1;
    tick(); tick();
    chk("t6_idle_busy", busy_o, 0);
    chk_csr("t6_idle_csr", 0, 32'h0);

    // T6b: async reset while in START
    cfg_en = 1'b1;
    tick();
    chk_csr("t6_start", 1, 32'h0);
    #2;
    rst_h = 1'b0;
    #1;
    chk_all_zero("t6_rst_start");
    cfg_en = 1'b0;
    tick();
    rst_h = 1'b1;
    tick(); tick();
    chk("t6b_idle_busy", busy_o, 0);
    chk("t6b_idle_we", csr_we_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
